// File: rtl/prbs_gen_check.sv
// prbs_gen_check: multi-polynomial PRBS generator plus self-synchronising
// checker used for link and pad-loopback testing.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   en               advance the generator by one OUT_W-bit word
//   mode             polynomial: 0 PRBS7, 1 PRBS15, 2 PRBS23, 3 PRBS31
//   inject_err       one-shot request to invert the LSB of the next word
//   gen_data/valid   generated word (MSB = earliest bit) and its strobe
//   chk_data/valid   received word (MSB = earliest bit) and its strobe
//   clr              synchronous clear of err_cnt
//   locked           checker is in LOCKED
//   err_cnt          saturating count of bit errors seen while LOCKED
module prbs_gen_check #(
    parameter int OUT_W    = 8,
    parameter int ERR_W    = 16,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             inject_err,
    output logic [OUT_W-1:0] gen_data,
    output logic             gen_valid,
    input  logic [OUT_W-1:0] chk_data,
    input  logic             chk_valid,
    input  logic             clr,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_CNT + 1);
    localparam int PW = $clog2(OUT_W + 1);
    localparam int SW = ((ERR_W > PW) ? ERR_W : PW) + 1;

    typedef enum logic {HUNT, LOCKED} state_t;

    // Tap positions as zero-based history indices (A-1, B-1).
    function automatic logic [4:0] tap_a(input logic [1:0] m);
        case (m)
            2'd0:    return 5'd6;
            2'd1:    return 5'd14;
            2'd2:    return 5'd22;
            default: return 5'd30;
        endcase
    endfunction

    function automatic logic [4:0] tap_b(input logic [1:0] m);
        case (m)
            2'd0:    return 5'd5;
            2'd1:    return 5'd13;
            2'd2:    return 5'd17;
            default: return 5'd27;
        endcase
    endfunction

    logic [1:0]       mode_q;
    logic             mode_chg;
    logic [4:0]       ta, tb;
    logic [30:0]      lfsr, lfsr_nx;
    logic [OUT_W-1:0] word;
    logic             pend, inj;

    assign mode_chg = (mode != mode_q);
    assign ta       = tap_a(mode_q);
    assign tb       = tap_b(mode_q);
    assign inj      = pend | inject_err;

    // Unroll OUT_W steps of the Fibonacci recurrence; bit 0 of the state is
    // the most recent bit.
    always_comb begin
        logic nb;
        nb      = 1'b0;
        lfsr_nx = lfsr;
        word    = '0;
        for (int i = OUT_W - 1; i >= 0; i--) begin
            nb      = lfsr_nx[ta] ^ lfsr_nx[tb];
            word[i] = nb;
            lfsr_nx = {lfsr_nx[29:0], nb};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr      <= '1;
            mode_q    <= mode;
            gen_data  <= '0;
            gen_valid <= 1'b0;
            pend      <= 1'b0;
        end else begin
            mode_q <= mode;
            if (mode_chg) begin
                // Restart the new polynomial from a known seed; no word this cycle.
                lfsr      <= '1;
                gen_valid <= 1'b0;
                pend      <= inj;
            end else if (en) begin
                // The inverted LSB is only on the wire; the LFSR keeps the true bit.
                lfsr      <= lfsr_nx;
                gen_data  <= word ^ OUT_W'(inj);
                gen_valid <= 1'b1;
                pend      <= 1'b0;
            end else begin
                gen_valid <= 1'b0;
                pend      <= inj;
            end
        end
    end

    // ---------------- checker ----------------
    state_t           state_q, state_d;
    logic [GW-1:0]    good, good_d;
    logic [BW-1:0]    bad, bad_d;
    logic [30:0]      hist, hist_d, hist_adv;
    logic [OUT_W-1:0] mm;
    logic [PW-1:0]    pc;
    logic [SW-1:0]    sum;
    logic [ERR_W-1:0] err_sat;

    // While hunting the history tracks the received bits so it can seed
    // itself; once locked it free-runs on expected bits so a single flipped
    // bit is counted exactly once.
    always_comb begin
        logic e;
        e        = 1'b0;
        hist_adv = hist;
        mm       = '0;
        for (int i = OUT_W - 1; i >= 0; i--) begin
            e        = hist_adv[ta] ^ hist_adv[tb];
            mm[i]    = chk_data[i] ^ e;
            hist_adv = {hist_adv[29:0], (state_q == LOCKED) ? e : chk_data[i]};
        end
    end

    always_comb begin
        pc = '0;
        for (int i = 0; i < OUT_W; i++) pc = pc + PW'(mm[i]);
    end

    assign sum     = SW'(err_cnt) + SW'(pc);
    assign err_sat = (sum[SW-1:ERR_W] != '0) ? '1 : sum[ERR_W-1:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= HUNT;
        else        state_q <= state_d;
    end

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        good_d  = good;
        bad_d   = bad;
        hist_d  = hist;
        if (mode_chg) begin
            state_d = HUNT;
            good_d  = '0;
            bad_d   = '0;
            hist_d  = '0;
        end else if (chk_valid) begin
            hist_d = hist_adv;
            case (state_q)
                HUNT: begin
                    if (mm == '0) begin
                        good_d = good + GW'(1);
                        if (good_d == GW'(LOCK_CNT)) begin
                            state_d = LOCKED;
                            bad_d   = '0;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                default: begin
                    if (mm != '0) begin
                        bad_d = bad + BW'(1);
                        if (bad_d == BW'(LOSS_CNT)) begin
                            state_d = HUNT;
                            good_d  = '0;
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        locked = (state_q == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist    <= '0;
            good    <= '0;
            bad     <= '0;
            err_cnt <= '0;
        end else begin
            hist <= hist_d;
            good <= good_d;
            bad  <= bad_d;
            if (clr)
                err_cnt <= '0;
            else if (!mode_chg && chk_valid && state_q == LOCKED)
                err_cnt <= err_sat;
        end
    end
endmodule

// File: tb/tb_prbs_gen_check.sv
module tb_prbs_gen_check;
    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       inject_err = 1'b0;
    logic [7:0] chk_data = 8'h00;
    logic       chk_valid = 1'b0;
    logic       clr = 1'b0;

    logic [7:0]  gen_data, gen_data4;
    logic        gen_valid, gen_valid4;
    logic        locked, locked4;
    logic [15:0] err_cnt;
    logic [3:0]  err_cnt4;

    prbs_gen_check #(.OUT_W(8), .ERR_W(16), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .inject_err(inject_err),
        .gen_data(gen_data), .gen_valid(gen_valid), .chk_data(chk_data),
        .chk_valid(chk_valid), .clr(clr), .locked(locked), .err_cnt(err_cnt));

    prbs_gen_check #(.OUT_W(8), .ERR_W(4), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .inject_err(inject_err),
        .gen_data(gen_data4), .gen_valid(gen_valid4), .chk_data(chk_data),
        .chk_valid(chk_valid), .clr(clr), .locked(locked4), .err_cnt(err_cnt4));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [30:0] m_lfsr;
    logic [1:0]  m_mode_q;
    logic [7:0]  m_gdata;
    logic        m_gvalid;
    logic        m_pend;
    logic [30:0] m_hist;
    logic        m_locked;
    int          m_good, m_bad, m_err, m_err4;
    logic [7:0]  gq[$];
    int          lb_mode = 0;   // 0 manual chk inputs, 1 loopback, 2 inverted loopback
    int          e_save;

    function automatic int tap_a(input logic [1:0] m);
        case (m)
            2'd0: return 7;
            2'd1: return 15;
            2'd2: return 23;
            default: return 31;
        endcase
    endfunction

    function automatic int tap_b(input logic [1:0] m);
        case (m)
            2'd0: return 6;
            2'd1: return 14;
            2'd2: return 18;
            default: return 28;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lfsr = '1; m_mode_q = mode; m_gdata = 8'h00; m_gvalid = 1'b0; m_pend = 1'b0;
        m_hist = '0; m_locked = 1'b0; m_good = 0; m_bad = 0; m_err = 0; m_err4 = 0;
        gq.delete();
    endtask

    task automatic model_edge();
        logic mc, e, nb;
        logic [7:0] w;
        int mmc, a, b;
        mc = (mode != m_mode_q);
        a = tap_a(m_mode_q);
        b = tap_b(m_mode_q);
        // checker
        if (mc) begin
            m_locked = 1'b0; m_good = 0; m_bad = 0; m_hist = '0;
        end else if (chk_valid) begin
            mmc = 0;
            for (int i = 7; i >= 0; i--) begin
                e = m_hist[a-1] ^ m_hist[b-1];
                if (chk_data[i] != e) mmc++;
                m_hist = {m_hist[29:0], m_locked ? e : chk_data[i]};
            end
            if (!m_locked) begin
                if (mmc == 0) begin
                    m_good++;
                    if (m_good == LOCK_CNT) begin m_locked = 1'b1; m_bad = 0; end
                end else m_good = 0;
            end else begin
                m_err  = (m_err + mmc > 65535) ? 65535 : m_err + mmc;
                m_err4 = (m_err4 + mmc > 15) ? 15 : m_err4 + mmc;
                if (mmc != 0) begin
                    m_bad++;
                    if (m_bad == LOSS_CNT) begin m_locked = 1'b0; m_good = 0; end
                end else m_bad = 0;
            end
        end
        if (clr) begin m_err = 0; m_err4 = 0; end
        // generator
        if (mc) begin
            m_lfsr = '1; m_gvalid = 1'b0; m_pend = m_pend | inject_err;
        end else if (en) begin
            w = 8'h00;
            for (int i = 7; i >= 0; i--) begin
                nb = m_lfsr[a-1] ^ m_lfsr[b-1];
                w[i] = nb;
                m_lfsr = {m_lfsr[29:0], nb};
            end
            if (m_pend || inject_err) w[0] = ~w[0];
            m_pend = 1'b0;
            m_gdata = w;
            m_gvalid = 1'b1;
            gq.push_back(w);
        end else begin
            m_gvalid = 1'b0; m_pend = m_pend | inject_err;
        end
        m_mode_q = mode;
    endtask

    // One clock: drive loopback inputs, advance the model, clock, compare.
    task automatic step();
        logic [7:0] exp;
        if (lb_mode == 1) begin chk_data = m_gdata; chk_valid = m_gvalid; end
        else if (lb_mode == 2) begin chk_data = ~m_gdata; chk_valid = m_gvalid; end
        model_edge();
        @(posedge clk); #1;
        chk("gen_valid", gen_valid, m_gvalid);
        if (gen_valid) begin
            if (gq.size() == 0) begin
                n_vec++; n_err++;
                $error("FAIL gen_unexpected observed=%0h expected=no word", gen_data);
            end else begin
                exp = gq.pop_front();
                chk("gen_data", gen_data, exp);
            end
        end else begin
            chk("gen_hold", gen_data, m_gdata);
            if (gq.size() != 0) begin
                n_vec++; n_err++;
                $error("FAIL gen_missing observed=no word expected=%0h", gq[0]);
                gq.delete();
            end
        end
        chk("gen_data_w4", gen_data4, m_gdata);
        chk("locked", locked, m_locked);
        chk("locked_w4", locked4, m_locked);
        chk("err_cnt", err_cnt, m_err);
        chk("err_cnt_w4", err_cnt4, m_err4);
        inject_err = 1'b0;
        clr = 1'b0;
    endtask

    initial begin
        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gen_data", gen_data, 8'h00);
        chk("rst_gen_valid", gen_valid, 1'b0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_err_cnt", err_cnt, 16'h0);
        rst_n = 1'b1;
        model_reset();

        // PRBS7 first word and period, with loopback locking
        en = 1'b1; lb_mode = 1;
        step();
        chk("prbs7_word0", gen_data, 8'h02);
        repeat (127) step();
        chk("prbs7_period", gen_data, 8'h02);
        repeat (50) step();
        chk("prbs7_locked", locked, 1'b1);
        chk("prbs7_err", err_cnt, 16'h0);

        // remaining polynomials in loopback
        for (int m = 1; m < 4; m++) begin
            mode = 2'(m);
            step();
            repeat (2500) step();
            chk("mode_locked", locked, 1'b1);
            chk("mode_err", err_cnt, 16'h0);
        end

        // PRBS31 injected errors, one requested while en is low
        en = 1'b0; inject_err = 1'b1; step();
        en = 1'b1; step();
        repeat (20) step();
        inject_err = 1'b1; step(); repeat (20) step();
        inject_err = 1'b1; step(); repeat (20) step();
        chk("inject_err3", err_cnt, 16'd3);
        chk("inject_locked", locked, 1'b1);
        clr = 1'b1; step();
        chk("clr_err", err_cnt, 16'd0);

        // clr beats a same-cycle increment, then saturation of the 4-bit counter
        lb_mode = 2; clr = 1'b1; step();
        chk("clr_prec", err_cnt, 16'd0);
        step(); step();
        chk("err_16", err_cnt, 16'd16);
        chk("err4_sat", err_cnt4, 4'hF);
        chk("still_locked", locked, 1'b1);
        lb_mode = 1; step();

        // constant 0xFF stream drops lock
        lb_mode = 0; chk_data = 8'hFF; chk_valid = 1'b1;
        repeat (8) step();
        chk("ff_unlocked", locked, 1'b0);
        chk("ff_err4_sat", err_cnt4, 4'hF);

        // relock at PRBS31, then switch to PRBS7 with en held high
        lb_mode = 1;
        repeat (100) step();
        chk("relock31", locked, 1'b1);
        e_save = m_err;
        mode = 2'd0; step();
        chk("swap_gen_valid", gen_valid, 1'b0);
        chk("swap_unlocked", locked, 1'b0);
        chk("swap_err_hold", err_cnt, 16'(e_save));
        step();
        chk("swap_word0", gen_data, 8'h02);
        repeat (50) step();
        chk("swap_relock", locked, 1'b1);
        chk("swap_err_final", err_cnt, 16'(e_save));

        // asynchronous reset mid-cycle
        #3 rst_n = 1'b0;
        #1;
        chk("arst_gen_data", gen_data, 8'h00);
        chk("arst_gen_valid", gen_valid, 1'b0);
        chk("arst_locked", locked, 1'b0);
        chk("arst_err_cnt", err_cnt, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
